// File: rtl/fifo_tg_pkg.sv
// fifo_tg_pkg: mode/state encodings and LFSR taps shared by the FIFO traffic generator.
package fifo_tg_pkg;
    typedef enum logic [1:0] {MODE_BURST = 2'd0, MODE_INTERLEAVE = 2'd1, MODE_RANDOM = 2'd2} mode_t;
    typedef enum logic [2:0] {IDLE, RUN_W, RUN_R, RUN_MIX, DONE} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/fifo_tg_lfsr16.sv
// fifo_tg_lfsr16: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) that steps while en_i is high.
module fifo_tg_lfsr16
    import fifo_tg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en_i,
    output logic bit_o
);
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = en_i ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
    assign bit_o  = lfsr_q[0];

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) lfsr_q <= SEED;
        else lfsr_q <= lfsr_d;
endmodule

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: burst / interleaved / pseudo-random write+read traffic for a FIFO under test.
// Define FIFO_TRAFFIC_CHECK_EN to add read-back checking (err_cnt, mismatch).
module fifo_traffic_gen
    import fifo_tg_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                CNT_W      = 8,
    parameter logic [DATA_W-1:0] DATA_START = DATA_W'(1),
    parameter logic [15:0]       LFSR_SEED  = 16'hACE1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              full,
    input  logic              empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              write,
    output logic              read,
    output logic              busy,
    output logic              done
`ifdef FIFO_TRAFFIC_CHECK_EN
    ,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              mismatch
`endif
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rnd_q, rnd_d, slot_q, slot_d;
    logic              write_q, write_d, read_q, read_d, busy_q, busy_d, done_q, done_d;
    logic              lfsr_bit, wr_left, rd_left, pick_w, accept;

    fifo_tg_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .en_i  (state_q == RUN_MIX),
        .bit_o (lfsr_bit)
    );

    assign accept  = state_q == IDLE && start;
    assign wr_left = wr_cnt_q != len_q;
    assign rd_left = rd_cnt_q != len_q;
    // Random mode falls back to the other side once its chosen side is exhausted.
    assign pick_w  = rnd_q ? (lfsr_bit ? wr_left : !rd_left) : !slot_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rnd_d   = rnd_q;
        slot_d  = slot_q;
        data_d  = write_q ? data_q + 1'b1 : data_q;
        write_d = 1'b0;
        read_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                len_d   = burst_len;
                rnd_d   = mode == MODE_RANDOM;
                slot_d  = 1'b0;
                data_d  = DATA_START;
                state_d = burst_len == '0 ? DONE
                        : (mode == MODE_INTERLEAVE || mode == MODE_RANDOM) ? RUN_MIX : RUN_W;
            end
            // A full FIFO hands over to the read phase to drain; writing resumes once it is empty.
            RUN_W: if (!wr_left || full) state_d = RUN_R;
                   else write_d = 1'b1;
            RUN_R: if (!rd_left) state_d = DONE;
                   else if (!empty) read_d = 1'b1;
                   else if (wr_left) state_d = RUN_W;
            RUN_MIX: if (!wr_left && !rd_left) state_d = DONE;
                     else begin
                         slot_d  = !slot_q;
                         write_d = pick_w && wr_left && !full;
                         read_d  = !pick_w && rd_left && !empty;
                     end
            default: state_d = IDLE;
        endcase
        wr_cnt_d = accept ? '0 : wr_cnt_q + CNT_W'(write_d);
        rd_cnt_d = accept ? '0 : rd_cnt_q + CNT_W'(read_d);
        busy_d   = state_d inside {RUN_W, RUN_R, RUN_MIX};
        done_d   = state_d == DONE && state_q != DONE;
    end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            state_q  <= IDLE;
            len_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            data_q   <= '0;
            rnd_q    <= 1'b0;
            slot_q   <= 1'b0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            data_q   <= data_d;
            rnd_q    <= rnd_d;
            slot_q   <= slot_d;
            write_q  <= write_d;
            read_q   <= read_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end

    assign data_out = data_q;
    assign write    = write_q;
    assign read     = read_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef FIFO_TRAFFIC_CHECK_EN
    logic              chk_q, mis_q, bad;
    logic [DATA_W-1:0] exp_q;
    logic [CNT_W-1:0]  err_q;

    // rd_data is valid the cycle after a read strobe, so compare one cycle behind read_q.
    assign bad = chk_q && rd_data != exp_q;

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            chk_q <= 1'b0;
            mis_q <= 1'b0;
            exp_q <= DATA_START;
            err_q <= '0;
        end else begin
            chk_q <= read_q;
            mis_q <= bad;
            if (accept) begin
                exp_q <= DATA_START;
                err_q <= '0;
            end else begin
                if (chk_q) exp_q <= exp_q + 1'b1;
                if (bad && !(&err_q)) err_q <= err_q + 1'b1;
            end
        end

    assign err_cnt  = err_q;
    assign mismatch = mis_q;
`else
    logic unused_rd;
    assign unused_rd = ^rd_data;
`endif
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: drives fifo_traffic_gen against a 16-deep FIFO model and scoreboards the read-back order.
module tb_fifo_traffic_gen;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0, RESET = 1'b1, start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [CW-1:0] burst_len = '0;
    logic [DW-1:0] rd_data = '0, data_out, pop;
    logic          full, empty, write, read, busy, done;
`ifdef FIFO_TRAFFIC_CHECK_EN
    logic [CW-1:0] err_cnt;
    logic          mismatch;
    int            mis_cyc[$];
`endif

    int            checks = 0, errors = 0;
    logic [DW-1:0] fq[$], exp_q[$], wr_log[$], rd_log[$];
    bit            st_log[$];
    int            rd_cyc[$];
    int            fcnt = 0, viol = 0, both = 0, xflow = 0, done_cnt = 0, saw_full = 0;
    int            rd_idx = 0, corrupt_idx = 0, cyc = 0;
    bit            rd_pend = 1'b0, pfull = 1'b0, pempty = 1'b1;

    always #5 CLK = ~CLK;

    fifo_traffic_gen dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .mode      (mode),
        .burst_len (burst_len),
        .full      (full),
        .empty     (empty),
        .rd_data   (rd_data),
        .data_out  (data_out),
        .write     (write),
        .read      (read),
        .busy      (busy),
        .done      (done)
`ifdef FIFO_TRAFFIC_CHECK_EN
        ,
        .err_cnt   (err_cnt),
        .mismatch  (mismatch)
`endif
    );

    // FIFO flags reflect the occupancy after the strobe currently in flight.
    assign full  = (fcnt + int'(write) - int'(read)) >= DEPTH;
    assign empty = (fcnt + int'(write) - int'(read)) <= 0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fq.delete();
            fcnt <= 0;
        end else begin
            if (start) rd_idx = 0;
            if (write) begin
                if (fq.size() >= DEPTH) xflow++;
                else fq.push_back(data_out);
            end
            if (read) begin
                if (fq.size() == 0) xflow++;
                else begin
                    rd_idx++;
                    pop = fq.pop_front();
                    rd_data <= (rd_idx == corrupt_idx) ? 32'hDEAD : pop;
                end
            end
            fcnt <= fq.size();
        end
    end

    always @(negedge CLK) begin
        cyc++;
        if (write) begin
            wr_log.push_back(data_out);
            if (pfull) viol++;
        end
        if (read && pempty) viol++;
        if (write && read) both++;
        if (write || read) st_log.push_back(write);
        if (rd_pend) begin
            rd_log.push_back(rd_data);
            rd_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (full) saw_full++;
`ifdef FIFO_TRAFFIC_CHECK_EN
        if (mismatch) mis_cyc.push_back(cyc);
`endif
        rd_pend = read;
        pfull   = full;
        pempty  = empty;
    end

    task automatic run(input logic [1:0] m, input int n, input int poke);
        int d0, w;
        d0 = done_cnt;
        @(negedge CLK);
        mode = m;
        burst_len = CW'(n);
        start = 1'b1;
        w = 0;
        do begin
            @(negedge CLK);
            start = (w == poke);
            w++;
        end while (done_cnt == d0 && w < 2000);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL run_timeout: mode %0d len %0d, no done after %0d cycles", m, n, w);
        end
    endtask

    task automatic test_reset();
        #1;
        checks += 5;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", data_out); end
        if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", write); end
        if (read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", read); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_traffic(input logic [1:0] m, input int n, input int poke);
        int wb, rb, v0, b0, x0, d0;
        logic [DW-1:0] e, got;
        wb = wr_log.size(); rb = rd_log.size();
        v0 = viol; b0 = both; x0 = xflow; d0 = done_cnt;
        for (int i = 0; i < n; i++) exp_q.push_back((i + 1 == corrupt_idx) ? 32'hDEAD : DW'(i + 1));
        run(m, n, poke);
        checks += 7;
        if (wr_log.size() - wb != n) begin errors++; $display("FAIL wr_count m%0d: got %0d expected %0d", m, wr_log.size() - wb, n); end
        if (rd_log.size() - rb != n) begin errors++; $display("FAIL rd_count m%0d: got %0d expected %0d", m, rd_log.size() - rb, n); end
        if (viol != v0) begin errors++; $display("FAIL flag_rule m%0d: got %0d strobes against a set flag, expected 0", m, viol - v0); end
        if (both != b0) begin errors++; $display("FAIL wr_rd_overlap m%0d: got %0d cycles, expected 0", m, both - b0); end
        if (xflow != x0) begin errors++; $display("FAIL fifo_xflow m%0d: got %0d, expected 0", m, xflow - x0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL done_pulse m%0d: got %0d cycles, expected 1", m, done_cnt - d0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after m%0d: got %b expected 0", m, busy); end
        for (int i = 0; i < n && wb + i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[wb + i] !== DW'(i + 1)) begin
                errors++;
                $display("FAIL wdata m%0d #%0d: got %0h expected %0h", m, i, wr_log[wb + i], i + 1);
            end
        end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            got = (rb + i < rd_log.size()) ? rd_log[rb + i] : 'x;
            checks++;
            if (got !== e) begin errors++; $display("FAIL rdata m%0d #%0d: got %0h expected %0h", m, i, got, e); end
        end
        if (n > 0) begin
            checks++;
            if (data_out !== DW'(n + 1)) begin errors++; $display("FAIL data_hold m%0d: got %0h expected %0h", m, data_out, n + 1); end
        end
`ifdef FIFO_TRAFFIC_CHECK_EN
        checks++;
        if (err_cnt !== CW'((corrupt_idx != 0 && corrupt_idx <= n) ? 1 : 0)) begin
            errors++;
            $display("FAIL err_cnt m%0d: got %0d", m, err_cnt);
        end
`endif
    endtask

    task automatic test_burst(input logic [1:0] m, input int n);
        int sb;
        sb = st_log.size();
        test_traffic(m, n, -1);
        for (int i = 0; i < 2 * n && sb + i < st_log.size(); i++) begin
            checks++;
            if (st_log[sb + i] !== (i < n)) begin
                errors++;
                $display("FAIL burst_order m%0d slot %0d: got write=%b expected write=%b", m, i, st_log[sb + i], i < n);
            end
        end
    endtask

    task automatic test_full();
        int sb, sf;
        sb = st_log.size(); sf = saw_full;
        test_traffic(2'd0, 20, -1);
        checks++;
        if (saw_full == sf) begin errors++; $display("FAIL full_seen: got 0 full cycles, expected some"); end
        for (int i = 0; i < 40 && sb + i < st_log.size(); i++) begin
            checks++;
            if (st_log[sb + i] !== (i < 16 || (i >= 32 && i < 36))) begin
                errors++;
                $display("FAIL full_order slot %0d: got write=%b", i, st_log[sb + i]);
            end
        end
    endtask

    task automatic test_interleave();
        int sb;
        sb = st_log.size();
        test_traffic(2'd1, 8, 3);
        checks++;
        if (st_log.size() - sb != 16) begin errors++; $display("FAIL il_count: got %0d strobes expected 16", st_log.size() - sb); end
        for (int i = 0; i < 16 && sb + i < st_log.size(); i++) begin
            checks++;
            if (st_log[sb + i] !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL il_alternate slot %0d: got write=%b expected write=%b", i, st_log[sb + i], i % 2 == 0);
            end
        end
    endtask

    task automatic test_random();
        test_traffic(2'd2, 32, -1);
    endtask

    task automatic test_zero_len();
        int wb, rb, d0;
        wb = wr_log.size(); rb = rd_log.size(); d0 = done_cnt;
        run(2'd0, 0, -1);
        checks += 3;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", done_cnt - d0); end
        if (wr_log.size() != wb) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wr_log.size() - wb); end
        if (rd_log.size() != rb) begin errors++; $display("FAIL zero_reads: got %0d expected 0", rd_log.size() - rb); end
    endtask

    task automatic test_mid_reset();
        int w, d0;
        @(negedge CLK);
        mode = 2'd0; burst_len = CW'(10); start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        w = 0;
        while (!(write === 1'b1 && data_out === DW'(5)) && w < 100) begin @(negedge CLK); w++; end
        d0 = done_cnt;
        #2 RESET = 1'b1;
        #1;
        checks += 5;
        if (w >= 100) begin errors++; $display("FAIL mid_fifth_write: got none within %0d cycles", w); end
        if (write !== 1'b0) begin errors++; $display("FAIL mid_write: got %b expected 0", write); end
        if (read !== 1'b0) begin errors++; $display("FAIL mid_read: got %b expected 0", read); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        if (data_out !== '0) begin errors++; $display("FAIL mid_data: got %0h expected 0", data_out); end
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt - d0); end
        test_traffic(2'd0, 3, -1);
    endtask

`ifdef FIFO_TRAFFIC_CHECK_EN
    task automatic test_check();
        int rb, mc;
        rb = rd_log.size(); mc = mis_cyc.size();
        corrupt_idx = 3;
        test_traffic(2'd0, 5, -1);
        corrupt_idx = 0;
        checks += 2;
        if (mis_cyc.size() - mc != 1) begin errors++; $display("FAIL mis_pulses: got %0d expected 1", mis_cyc.size() - mc); end
        else if (rd_log.size() - rb < 3 || mis_cyc[mc] != rd_cyc[rb + 2] + 1) begin
            errors++;
            $display("FAIL mis_timing: got cycle %0d expected one after bad data", mis_cyc[mc]);
        end
        if (err_cnt !== CW'(1)) begin errors++; $display("FAIL err_before_start: got %0d expected 1", err_cnt); end
        @(negedge CLK);
        mode = 2'd0; burst_len = CW'(1); start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (err_cnt !== '0) begin errors++; $display("FAIL err_clear: got %0d expected 0", err_cnt); end
        repeat (20) @(negedge CLK);
    endtask
`endif

    initial begin
        test_reset();
        test_burst(2'd0, 14);
        test_full();
        test_interleave();
        test_random();
        test_burst(2'd3, 2);
        test_zero_len();
        test_mid_reset();
`ifdef FIFO_TRAFFIC_CHECK_EN
        test_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
